// File: rtl/uart_pkg.sv
// Shared definitions for the UART loopback path: TX FSM encoding,
// default widths and the FIFO level width helper.
package uart_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_t;

  // Level must represent 0..2^addr_w inclusive, hence one extra bit.
  function automatic int level_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular buffer with a separate occupancy counter.
// Push is accepted when not full, or when a pop frees a slot in the same cycle.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                        sysclk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  output logic [DATA_W-1:0]           pop_data,
  output logic                        full,
  output logic                        empty,
  output logic [level_w(ADDR_W)-1:0] level,
  output logic [level_w(ADDR_W)-1:0] level_next
);

  localparam int             LW      = level_w(ADDR_W);
  localparam logic [LW-1:0]  DEPTH_L = LW'(2 ** ADDR_W);

  logic [DATA_W-1:0] mem [2 ** ADDR_W];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full     = (level == DEPTH_L);
  assign empty    = (level == '0);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_comb begin
    level_next = level;
    if (push_ok && !pop_ok)
      level_next = level + LW'(1);
    else if (pop_ok && !push_ok)
      level_next = level - LW'(1);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + ADDR_W'(1);
      level <= level_next;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge sysclk) begin
    if (push_ok)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_loopback_ctrl.sv
// Buffers received bytes in a FIFO and replays them in order to the
// transmitter, flagging any byte dropped because the FIFO was full.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for data; pops the head into tx_data when non-empty
// ST_SEND | tx_en_sig high, holding tx_data until tx_done_sig
// ST_GAP  | one cycle with tx_en_sig low so the transmitter re-arms
module uart_loopback_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                        sysclk,
  input  logic                        rst_n,
  input  logic                        rx_done_sig,
  input  logic [DATA_W-1:0]           rx_data,
  output logic                        rx_en_sig,
  input  logic                        tx_done_sig,
  output logic                        tx_en_sig,
  output logic [DATA_W-1:0]           tx_data,
  output logic [level_w(ADDR_W)-1:0] fifo_level,
  output logic                        overflow
);

  localparam int            LW      = level_w(ADDR_W);
  localparam logic [LW-1:0] DEPTH_L = LW'(2 ** ADDR_W);

  tx_state_t         state;
  logic              pop;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;
  logic [LW-1:0]     level_next;

  assign pop = (state == ST_IDLE) && !empty;

  sync_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .push       (rx_done_sig),
    .push_data  (rx_data),
    .pop        (pop),
    .pop_data   (head),
    .full       (full),
    .empty      (empty),
    .level      (fifo_level),
    .level_next (level_next)
  );

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tx_en_sig <= 1'b0;
      tx_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            tx_data   <= head;
            tx_en_sig <= 1'b1;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_done_sig) begin
            tx_en_sig <= 1'b0;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          tx_en_sig <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // A pop in the same cycle frees a slot, so a push at full is only a drop without one.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      rx_en_sig <= 1'b0;
    end else begin
      if (rx_done_sig && full && !pop)
        overflow <= 1'b1;
      rx_en_sig <= (level_next < DEPTH_L);
    end
  end

endmodule

// File: tb/tb_uart_loopback_ctrl.sv
// Directed and randomized checks of uart_loopback_ctrl against an
// in-order byte queue model of the loopback path.
module tb_uart_loopback_ctrl;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       rx_done_sig;
  logic [7:0] rx_data;
  logic       rx_en_sig;
  logic       tx_done_sig;
  logic       tx_en_sig;
  logic [7:0] tx_data;
  logic [4:0] fifo_level;
  logic       overflow;

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_tx  = 0;
  logic [7:0] exp_q [$];
  logic       prev_tx_en = 1'b0;

  always #5 sysclk = ~sysclk;

  uart_loopback_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .rx_done_sig (rx_done_sig),
    .rx_data     (rx_data),
    .rx_en_sig   (rx_en_sig),
    .tx_done_sig (tx_done_sig),
    .tx_en_sig   (tx_en_sig),
    .tx_data     (tx_data),
    .fifo_level  (fifo_level),
    .overflow    (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance to just after the edge, then check any new transmission.
  task automatic step(input logic rx, input logic [7:0] d, input logic txd, input logic keep = 1'b1);
    rx_done_sig = rx;
    rx_data     = d;
    tx_done_sig = txd;
    if (rx && keep)
      exp_q.push_back(d);
    @(posedge sysclk);
    #1;
    rx_done_sig = 1'b0;
    tx_done_sig = 1'b0;
    if (tx_en_sig && !prev_tx_en) begin
      n_tx++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL tx_unexpected: observed %02h expected no transmission", tx_data);
        end
      end else begin
        chk("tx_data_order", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
    prev_tx_en = tx_en_sig;
  endtask

  // End the current transmission and check GAP, IDLE, then whether the next byte starts.
  task automatic finish_tx(input string tag, input logic exp_next);
    step(1'b0, 8'h00, 1'b1);
    chk({tag, "_gap"}, {31'h0, tx_en_sig}, 32'h0);
    step(1'b0, 8'h00, 1'b0);
    chk({tag, "_idle"}, {31'h0, tx_en_sig}, 32'h0);
    step(1'b0, 8'h00, 1'b0);
    chk({tag, "_next"}, {31'h0, tx_en_sig}, {31'h0, exp_next});
  endtask

  initial begin
    int         n_sent;
    int         gap_cnt;
    int         tx_wait;
    logic       done_issued;
    logic       rx;
    logic       txd;
    logic [7:0] d;

    rst_n       = 1'b0;
    rx_done_sig = 1'b0;
    rx_data     = 8'h00;
    tx_done_sig = 1'b0;
    #12;
    chk("rst_tx_en",    {31'h0, tx_en_sig}, 32'h0);
    chk("rst_tx_data",  {24'h0, tx_data},   32'h0);
    chk("rst_level",    {27'h0, fifo_level}, 32'h0);
    chk("rst_overflow", {31'h0, overflow},  32'h0);
    chk("rst_rx_en",    {31'h0, rx_en_sig}, 32'h0);
    @(posedge sysclk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    chk("rx_en_after_release", {31'h0, rx_en_sig}, 32'h1);

    // Single byte latency
    step(1'b1, 8'h55, 1'b0);
    chk("t1_level_n1", {27'h0, fifo_level}, 32'h1);
    chk("t1_tx_en_n1", {31'h0, tx_en_sig}, 32'h0);
    step(1'b0, 8'h00, 1'b0);
    chk("t1_tx_en_n2", {31'h0, tx_en_sig}, 32'h1);
    chk("t1_level_n2", {27'h0, fifo_level}, 32'h0);
    step(1'b0, 8'h00, 1'b0);
    chk("t1_tx_data_hold", {24'h0, tx_data}, 32'h55);
    finish_tx("t1", 1'b0);
    chk("t1_level_end", {27'h0, fifo_level}, 32'h0);

    // Burst while the transmitter is busy with a lead byte
    step(1'b1, 8'hA0, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 5; i++)
      step(1'b1, 8'(i), 1'b0);
    chk("t2_level5", {27'h0, fifo_level}, 32'h5);
    chk("t2_tx_en",  {31'h0, tx_en_sig}, 32'h1);
    for (int i = 0; i < 6; i++)
      finish_tx("t2", i < 5);
    chk("t2_level_end", {27'h0, fifo_level}, 32'h0);

    // Fill to 16 queued (plus one in flight), then a dropped byte
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'h10 + 8'(i), 1'b0);
      if (i == 15) begin
        chk("t3_level15", {27'h0, fifo_level}, 32'd15);
        chk("t3_rx_en15", {31'h0, rx_en_sig}, 32'h1);
      end
    end
    chk("t3_level16",   {27'h0, fifo_level}, 32'd16);
    chk("t3_rx_en_low", {31'h0, rx_en_sig}, 32'h0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("t3_overflow",   {31'h0, overflow},  32'h1);
    chk("t3_level_held", {27'h0, fifo_level}, 32'd16);

    // Asynchronous reset while transmitting
    chk("t6_tx_en_pre", {31'h0, tx_en_sig}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_tx_en_async",    {31'h0, tx_en_sig}, 32'h0);
    chk("t6_level_async",    {27'h0, fifo_level}, 32'h0);
    chk("t6_overflow_async", {31'h0, overflow},  32'h0);
    @(posedge sysclk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    prev_tx_en = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    chk("t6_rx_en_back", {31'h0, rx_en_sig}, 32'h1);

    // Simultaneous push and pop at full
    for (int i = 0; i < 17; i++)
      step(1'b1, 8'h30 + 8'(i), 1'b0);
    chk("t5_level16", {27'h0, fifo_level}, 32'd16);
    step(1'b0, 8'h00, 1'b1);
    chk("t5_gap", {31'h0, tx_en_sig}, 32'h0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h99, 1'b0);
    chk("t5_level_kept", {27'h0, fifo_level}, 32'd16);
    chk("t5_no_overflow", {31'h0, overflow}, 32'h0);
    chk("t5_tx_en", {31'h0, tx_en_sig}, 32'h1);
    for (int i = 0; i < 17; i++)
      finish_tx("t5", i < 16);
    chk("t5_model_drained", exp_q.size(), 32'h0);
    chk("t5_level_end", {27'h0, fifo_level}, 32'h0);

    // Randomized steady stream through both pointer wraps
    n_tx        = 0;
    n_sent      = 0;
    gap_cnt     = 0;
    tx_wait     = 0;
    done_issued = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rx = 1'b0;
      d  = 8'h00;
      if (n_sent < 40 && gap_cnt == 0) begin
        rx      = 1'b1;
        d       = 8'($urandom);
        n_sent++;
        gap_cnt = $urandom_range(9, 6);
      end else if (gap_cnt > 0) begin
        gap_cnt--;
      end
      txd = 1'b0;
      if (tx_en_sig && !done_issued) begin
        if (tx_wait == 0) begin
          txd         = 1'b1;
          done_issued = 1'b1;
        end else begin
          tx_wait--;
        end
      end else if (!tx_en_sig) begin
        done_issued = 1'b0;
        tx_wait     = $urandom_range(2, 0);
      end
      step(rx, d, txd);
      if (n_sent == 40 && exp_q.size() == 0 && !tx_en_sig)
        break;
    end
    chk("wrap_model_drained", exp_q.size(), 32'h0);
    chk("wrap_tx_count", n_tx, 32'd40);
    chk("wrap_overflow", {31'h0, overflow}, 32'h0);
    chk("wrap_level", {27'h0, fifo_level}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
